// File: rtl/mem_io_sequencer.sv
// Async SRAM read/write sequencer with one memory-mapped switch/hex I/O address.
// Optional write protection below PROT_LIMIT when MEMIO_WRITE_PROTECT_EN is defined.
module mem_io_sequencer #(
  parameter int unsigned       ADDR_W      = 20,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(20'hFFFFF),
  parameter logic [ADDR_W-1:0] PROT_LIMIT  = ADDR_W'(20'h00000)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       Data_from_CPU,
  input  logic [15:0]       Data_from_SRAM,
  input  logic [15:0]       Switches,
  output logic [15:0]       Data_to_CPU,
  output logic [15:0]       Data_to_SRAM,
  output logic              DQ_Drive,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [15:0]       HEX_Data,
  output logic              Rd_Valid,
  output logic              Busy,
  output logic              Wr_Fault
);

  localparam int unsigned    CW      = 4;
  localparam logic [CW-1:0]  RD_LAST = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0]  WR_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, WR_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [15:0]   rd_buf;
  logic [15:0]   wr_data;
  logic          io_hit;

  assign io_hit = (ADDR == IO_ADDR);

`ifdef MEMIO_WRITE_PROTECT_EN
  logic wr_fault;
  logic prot_hit;
  assign prot_hit = (ADDR < PROT_LIMIT);
  assign Wr_Fault = wr_fault;
`else
  logic unused_prot_limit;
  assign unused_prot_limit = ^PROT_LIMIT;
  assign Wr_Fault = 1'b0;
`endif

  // Sequencer: counter is cleared on every state entry except the read wait, which starts at 1
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      count    <= '0;
      rd_buf   <= '0;
      wr_data  <= '0;
      HEX_Data <= '0;
      Rd_Valid <= 1'b0;
`ifdef MEMIO_WRITE_PROTECT_EN
      wr_fault <= 1'b0;
`endif
    end else begin
      Rd_Valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!Mem_WE) begin
            count <= '0;
            if (io_hit) begin
              HEX_Data <= Data_from_CPU;
              state    <= WR_DONE;
            end
`ifdef MEMIO_WRITE_PROTECT_EN
            else if (prot_hit) begin
              wr_fault <= 1'b1;
              state    <= WR_DONE;
            end
`endif
            else begin
              wr_data <= Data_from_CPU;
              state   <= WR_SETUP;
            end
          end else if (!Mem_OE && !io_hit) begin
            count <= CW'(1);
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (Mem_OE) begin
            count <= '0;
            state <= IDLE;
          end else if (count == RD_LAST) begin
            rd_buf   <= Data_from_SRAM;
            Rd_Valid <= 1'b1;
            count    <= '0;
            state    <= RD_DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        RD_DONE: begin
          if (Mem_OE) state <= IDLE;
        end
        WR_SETUP: begin
          count <= '0;
          state <= WR_PULSE;
        end
        WR_PULSE: begin
          if (count == WR_LAST) begin
            count <= '0;
            state <= WR_HOLD;
          end else begin
            count <= count + CW'(1);
          end
        end
        WR_HOLD: begin
          count <= '0;
          state <= WR_DONE;
        end
        WR_DONE: begin
          if (Mem_WE) state <= IDLE;
        end
        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // SRAM strobes decoded from state; OE follows the CPU strobe so data is usable in the first cycle
  assign SRAM_OE_N = !(!Mem_OE && !io_hit && Mem_WE && (state == IDLE || state == RD_WAIT));
  assign SRAM_WE_N = (state != WR_PULSE);
  assign DQ_Drive  = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
  assign Busy      = (state != IDLE);

  assign Data_to_SRAM = wr_data;
  assign Data_to_CPU  = io_hit ? Switches : (!SRAM_OE_N ? Data_from_SRAM : rd_buf);

endmodule

// File: tb/tb_mem_io_sequencer.sv
// Directed bench for mem_io_sequencer: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances with a read/write scoreboard.
module tb_mem_io_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [19:0] addr;
  logic [15:0] dcpu, dsram, sw;
  logic        oe1, we1, oe3, we3;

  logic [15:0] dtc1, dts1, hex1, dtc3, dts3, hex3;
  logic        dq1, oe_n1, we_n1, rdv1, busy1, wf1;
  logic        dq3, oe_n3, we_n3, rdv3, busy3, wf3;

  int n_checks = 0;
  int n_err    = 0;
  int n_rdv1 = 0, n_rdv3 = 0, n_wep1 = 0, n_wep3 = 0;
  int n_welow3 = 0, n_dq3 = 0, n_oelow1 = 0;
  int b_rdv, b_wep, b_welow, b_dq, b_oelow;
  logic prev_we1 = 1'b1, prev_we3 = 1'b1;

  logic [15:0] rd_q1[$], rd_q3[$], wr_q1[$], wr_q3[$];

  always #5 Clk = ~Clk;

  mem_io_sequencer #(.ADDR_W(20), .WAIT_CYCLES(1), .IO_ADDR(20'hFFFFF), .PROT_LIMIT(20'h00000)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Mem_OE(oe1), .Mem_WE(we1), .ADDR(addr),
    .Data_from_CPU(dcpu), .Data_from_SRAM(dsram), .Switches(sw),
    .Data_to_CPU(dtc1), .Data_to_SRAM(dts1), .DQ_Drive(dq1), .SRAM_OE_N(oe_n1),
    .SRAM_WE_N(we_n1), .HEX_Data(hex1), .Rd_Valid(rdv1), .Busy(busy1), .Wr_Fault(wf1)
  );

  mem_io_sequencer #(.ADDR_W(20), .WAIT_CYCLES(3), .IO_ADDR(20'hFFFFF), .PROT_LIMIT(20'h00100)) u_dut3 (
    .Clk(Clk), .Reset(Reset), .Mem_OE(oe3), .Mem_WE(we3), .ADDR(addr),
    .Data_from_CPU(dcpu), .Data_from_SRAM(dsram), .Switches(sw),
    .Data_to_CPU(dtc3), .Data_to_SRAM(dts3), .DQ_Drive(dq3), .SRAM_OE_N(oe_n3),
    .SRAM_WE_N(we_n3), .HEX_Data(hex3), .Rd_Valid(rdv3), .Busy(busy3), .Wr_Fault(wf3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on read captures and on each SRAM write strobe
  always @(negedge Clk) begin
    if (rdv1) begin
      n_rdv1++;
      if (rd_q1.size() == 0) chk("rd1_unexpected", 32'(rdv1), 32'd0);
      else chk("rd1_data", 32'(dtc1), 32'(rd_q1.pop_front()));
    end
    if (rdv3) begin
      n_rdv3++;
      if (rd_q3.size() == 0) chk("rd3_unexpected", 32'(rdv3), 32'd0);
      else chk("rd3_data", 32'(dtc3), 32'(rd_q3.pop_front()));
    end
    if (prev_we1 && !we_n1) begin
      n_wep1++;
      if (wr_q1.size() == 0) chk("wr1_unexpected", 32'(we_n1), 32'd1);
      else chk("wr1_data", 32'(dts1), 32'(wr_q1.pop_front()));
    end
    if (prev_we3 && !we_n3) begin
      n_wep3++;
      if (wr_q3.size() == 0) chk("wr3_unexpected", 32'(we_n3), 32'd1);
      else chk("wr3_data", 32'(dts3), 32'(wr_q3.pop_front()));
    end
    prev_we1 = we_n1;
    prev_we3 = we_n3;
    if (!we_n3) n_welow3++;
    if (dq3)    n_dq3++;
    if (!oe_n1) n_oelow1++;
    chk("dq_oe_excl1", 32'(dq1 && !oe_n1), 32'd0);
    chk("dq_oe_excl3", 32'(dq3 && !oe_n3), 32'd0);
  end

  initial begin
    Reset = 1'b1; addr = '0; dcpu = '0; dsram = '0; sw = '0;
    oe1 = 1'b1; we1 = 1'b1; oe3 = 1'b1; we3 = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_oe_n",  32'(oe_n1), 32'd1);
    chk("rst_we_n",  32'(we_n3), 32'd1);
    chk("rst_dq",    32'(dq3),   32'd0);
    chk("rst_hex",   32'(hex3),  32'd0);
    chk("rst_rdv",   32'(rdv1),  32'd0);
    chk("rst_busy",  32'(busy3), 32'd0);
    chk("rst_wf",    32'(wf3),   32'd0);
    chk("rst_rdbuf", 32'(dtc1),  32'd0);
    @(posedge Clk); #1 Reset = 1'b0;

    // two-cycle read at WAIT_CYCLES=1
    tick(); addr = 20'h00010; dsram = 16'hBEEF; oe1 = 1'b0; rd_q1.push_back(16'hBEEF); b_rdv = n_rdv1;
    @(negedge Clk);
    chk("rd_c0_oe_n", 32'(oe_n1), 32'd0);
    chk("rd_c0_data", 32'(dtc1), 32'hBEEF);
    chk("rd_c0_busy", 32'(busy1), 32'd0);
    tick(); @(negedge Clk);
    chk("rd_c1_oe_n", 32'(oe_n1), 32'd0);
    chk("rd_c1_data", 32'(dtc1), 32'hBEEF);
    chk("rd_c1_busy", 32'(busy1), 32'd1);
    tick(); oe1 = 1'b1; dsram = 16'h0000;
    @(negedge Clk);
    chk("rd_done_oe_n", 32'(oe_n1), 32'd1);
    chk("rd_valid_hi",  32'(rdv1), 32'd1);
    tick(); @(negedge Clk);
    chk("rd_valid_lo",  32'(rdv1), 32'd0);
    chk("rd_idle",      32'(busy1), 32'd0);
    chk("rd_buf_hold",  32'(dtc1), 32'hBEEF);
    chk("rd_valid_cnt", 32'(n_rdv1 - b_rdv), 32'd1);

    // read aborted by early OE release at WAIT_CYCLES=3
    tick(); dsram = 16'h1111; oe3 = 1'b0; b_rdv = n_rdv3;
    tick();
    tick(); oe3 = 1'b1;
    @(negedge Clk);
    chk("abort_oe_n", 32'(oe_n3), 32'd1);
    chk("abort_busy", 32'(busy3), 32'd1);
    tick(); @(negedge Clk);
    chk("abort_idle",    32'(busy3), 32'd0);
    chk("abort_no_cap",  32'(dtc3), 32'd0);
    chk("abort_no_rdv",  32'(n_rdv3 - b_rdv), 32'd0);

    // long write strobe at WAIT_CYCLES=3
    tick(); addr = 20'h00020; dcpu = 16'h1234; we3 = 1'b0; wr_q3.push_back(16'h1234);
    b_wep = n_wep3; b_welow = n_welow3; b_dq = n_dq3;
    tick(); dcpu = 16'hFFFF;
    @(negedge Clk);
    chk("wr_setup_dq",  32'(dq3), 32'd1);
    chk("wr_setup_we",  32'(we_n3), 32'd1);
    repeat (8) tick();
    @(negedge Clk);
    chk("wr_busy_held", 32'(busy3), 32'd1);
    tick(); we3 = 1'b1;
    tick(); @(negedge Clk);
    chk("wr_idle",      32'(busy3), 32'd0);
    chk("wr_pulses",    32'(n_wep3 - b_wep), 32'd1);
    chk("wr_we_low",    32'(n_welow3 - b_welow), 32'd3);
    chk("wr_dq_cycles", 32'(n_dq3 - b_dq), 32'd5);

    // I/O write to the hex register
    tick(); addr = 20'hFFFFF; dcpu = 16'h00A5; we1 = 1'b0; b_wep = n_wep1;
    @(negedge Clk);
    chk("io_wr_we_c0", 32'(we_n1), 32'd1);
    tick(); we1 = 1'b1;
    @(negedge Clk);
    chk("io_wr_hex",   32'(hex1), 32'h00A5);
    chk("io_wr_we_c1", 32'(we_n1), 32'd1);
    tick(); @(negedge Clk);
    chk("io_wr_idle",  32'(busy1), 32'd0);
    chk("io_wr_nopulse", 32'(n_wep1 - b_wep), 32'd0);

    // I/O read of the switches
    tick(); sw = 16'h0F0F; oe1 = 1'b0;
    @(negedge Clk);
    chk("io_rd_data", 32'(dtc1), 32'h0F0F);
    chk("io_rd_oe_n", 32'(oe_n1), 32'd1);
    tick(); @(negedge Clk);
    chk("io_rd_idle", 32'(busy1), 32'd0);
    chk("io_rd_oe_n2", 32'(oe_n1), 32'd1);
    tick(); oe1 = 1'b1;

    // both strobes low: write wins, OE never asserted
    tick(); addr = 20'h00030; dcpu = 16'h5A5A; oe1 = 1'b0; we1 = 1'b0; wr_q1.push_back(16'h5A5A);
    b_wep = n_wep1; b_oelow = n_oelow1;
    repeat (6) tick();
    oe1 = 1'b1; we1 = 1'b1;
    tick(); tick(); @(negedge Clk);
    chk("both_pulses", 32'(n_wep1 - b_wep), 32'd1);
    chk("both_no_oe",  32'(n_oelow1 - b_oelow), 32'd0);
    chk("both_idle",   32'(busy1), 32'd0);

    // asynchronous reset in the middle of the write pulse
    tick(); addr = 20'h00040; dcpu = 16'h7777; we3 = 1'b0; wr_q3.push_back(16'h7777);
    tick();
    tick(); @(negedge Clk);
    chk("mid_pulse_we", 32'(we_n3), 32'd0);
    chk("mid_pulse_dq", 32'(dq3), 32'd1);
    #1 Reset = 1'b1;
    #1;
    chk("arst_we_n",  32'(we_n3), 32'd1);
    chk("arst_dq",    32'(dq3), 32'd0);
    chk("arst_busy",  32'(busy3), 32'd0);
    chk("arst_hex",   32'(hex1), 32'd0);
    chk("arst_rdbuf", 32'(dtc1), 32'd0);
    we3 = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;

    // write below the protection limit
    tick(); addr = 20'h00050; dcpu = 16'h0BAD; we3 = 1'b0;
    b_wep = n_wep3; b_dq = n_dq3;
`ifndef MEMIO_WRITE_PROTECT_EN
    wr_q3.push_back(16'h0BAD);
`endif
    repeat (7) tick();
    we3 = 1'b1;
    tick(); tick(); @(negedge Clk);
`ifdef MEMIO_WRITE_PROTECT_EN
    chk("prot_no_pulse", 32'(n_wep3 - b_wep), 32'd0);
    chk("prot_no_dq",    32'(n_dq3 - b_dq), 32'd0);
    chk("prot_fault",    32'(wf3), 32'd1);
`else
    chk("noprot_pulse",  32'(n_wep3 - b_wep), 32'd1);
    chk("noprot_dq",     32'(n_dq3 - b_dq), 32'd5);
    chk("noprot_fault",  32'(wf3), 32'd0);
`endif
    chk("prot_idle", 32'(busy3), 32'd0);

    // legal write afterwards completes; fault flag is sticky
    tick(); addr = 20'h00200; dcpu = 16'hC0DE; we3 = 1'b0; wr_q3.push_back(16'hC0DE);
    b_wep = n_wep3;
    repeat (7) tick();
    we3 = 1'b1;
    tick(); tick(); @(negedge Clk);
    chk("legal_pulse", 32'(n_wep3 - b_wep), 32'd1);
    chk("legal_idle",  32'(busy3), 32'd0);
`ifdef MEMIO_WRITE_PROTECT_EN
    chk("fault_sticky", 32'(wf3), 32'd1);
`else
    chk("fault_tied",   32'(wf3), 32'd0);
`endif
    chk("wf1_clear", 32'(wf1), 32'd0);

    chk("rd_q1_empty", 32'(rd_q1.size()), 32'd0);
    chk("rd_q3_empty", 32'(rd_q3.size()), 32'd0);
    chk("wr_q1_empty", 32'(wr_q1.size()), 32'd0);
    chk("wr_q3_empty", 32'(wr_q3.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
